// File: rtl/read_axi_buffer.sv
// AXI4 read master for cache refill: one request at a time, assembles a line (or one word) and pulses done.
// Define READ_AXI_WRAP_EN for critical-word-first WRAP bursts on cached requests.
module read_axi_buffer #(
  parameter int LINE_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   uncached,
  input  logic [31:0]            addr,
  input  logic [2:0]             size,
  output logic                   empty,
  output logic                   done,
  output logic                   resp_err,
  output logic [31:0]            word_data,
  output logic [LINE_SIZE*8-1:0] line_data,
  output logic [31:0]            axi_araddr,
  output logic [7:0]             axi_arlen,
  output logic [1:0]             axi_arburst,
  output logic [2:0]             axi_arsize,
  output logic                   axi_arvalid,
  input  logic                   axi_arready,
  input  logic [31:0]            axi_rdata,
  input  logic [1:0]             axi_rresp,
  input  logic                   axi_rlast,
  input  logic                   axi_rvalid,
  output logic                   axi_rready
);

  localparam int BEATS = LINE_SIZE / 4;
  localparam int LW    = $clog2(LINE_SIZE);
  localparam int IW    = $clog2(BEATS);
  localparam int CW    = IW + 1;

  typedef enum logic [1:0] {IDLE, WAIT_ADDR, WAIT_DATA, DONE} state_t;

  state_t          state;
  logic            req_uncached;
  logic [31:0]     req_addr;
  logic [2:0]      req_size;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   cnt;

  logic            src_uncached;
  logic [31:0]     src_addr;
  logic [2:0]      src_size;
  logic [IW-1:0]   start_idx;
  logic            beat;
  logic            last_beat;
  logic            unused_ok;

  assign empty      = (state == IDLE);
  assign done       = (state == DONE);
  assign axi_rready = (state == WAIT_DATA);
  assign beat       = axi_rvalid & axi_rready;
  assign last_beat  = req_uncached || (cnt == CW'(BEATS - 1));
  // completion is counted, so rlast and the OKAY/EXOKAY bit carry no information here
  assign unused_ok  = &{1'b0, axi_rlast, axi_rresp[0]};

  // In IDLE the AR channel follows the request inputs directly; afterwards it replays the captured request.
  always_comb begin
    src_uncached = (state == IDLE) ? uncached : req_uncached;
    src_addr     = (state == IDLE) ? addr     : req_addr;
    src_size     = (state == IDLE) ? size     : req_size;
    axi_araddr   = '0;
    axi_arlen    = '0;
    axi_arburst  = '0;
    axi_arsize   = '0;
    axi_arvalid  = 1'b0;
    if ((state == IDLE && en) || state == WAIT_ADDR) begin
      axi_arvalid = 1'b1;
      if (src_uncached) begin
        axi_araddr = src_addr;
        axi_arsize = src_size;
      end else begin
`ifdef READ_AXI_WRAP_EN
        axi_araddr  = {src_addr[31:2], 2'b00};
        axi_arburst = 2'b10;
`else
        axi_araddr  = {src_addr[31:LW], {LW{1'b0}}};
        axi_arburst = 2'b01;
`endif
        axi_arlen  = 8'(BEATS - 1);
        axi_arsize = 3'b010;
      end
    end
  end

  always_comb begin
`ifdef READ_AXI_WRAP_EN
    start_idx = uncached ? '0 : addr[LW-1:2];
`else
    start_idx = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_uncached <= 1'b0;
      req_addr     <= '0;
      req_size     <= '0;
      idx          <= '0;
      cnt          <= '0;
      resp_err     <= 1'b0;
      word_data    <= '0;
      line_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            req_uncached <= uncached;
            req_addr     <= addr;
            req_size     <= size;
            resp_err     <= 1'b0;
            cnt          <= '0;
            idx          <= start_idx;
            state        <= axi_arready ? WAIT_DATA : WAIT_ADDR;
          end
        end
        WAIT_ADDR: begin
          if (axi_arready) state <= WAIT_DATA;
        end
        WAIT_DATA: begin
          if (beat) begin
            line_data[idx*32 +: 32] <= axi_rdata;
            if (req_uncached) word_data <= axi_rdata;
            resp_err <= resp_err | axi_rresp[1];
            idx      <= idx + IW'(1);
            cnt      <= cnt + CW'(1);
            if (last_beat) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_read_axi_buffer.sv
// Self-checking bench for read_axi_buffer: bench acts as cache controller and AXI slave,
// a transaction-level model predicts every output each cycle (honours READ_AXI_WRAP_EN).
module tb_read_axi_buffer;
  localparam int LS    = 16;
  localparam int BEATS = LS / 4;
`ifdef READ_AXI_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic            clk, rst, en, uncached;
  logic [31:0]     addr;
  logic [2:0]      size;
  logic            empty, done, resp_err;
  logic [31:0]     word_data;
  logic [LS*8-1:0] line_data;
  logic [31:0]     axi_araddr;
  logic [7:0]      axi_arlen;
  logic [1:0]      axi_arburst;
  logic [2:0]      axi_arsize;
  logic            axi_arvalid, axi_arready;
  logic [31:0]     axi_rdata;
  logic [1:0]      axi_rresp;
  logic            axi_rlast, axi_rvalid, axi_rready;

  read_axi_buffer #(.LINE_SIZE(LS)) dut (
    .clk(clk), .rst(rst), .en(en), .uncached(uncached), .addr(addr), .size(size),
    .empty(empty), .done(done), .resp_err(resp_err), .word_data(word_data), .line_data(line_data),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arburst(axi_arburst), .axi_arsize(axi_arsize),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // model state
  logic        exp_empty, exp_done, exp_rready, exp_arvalid, exp_err;
  logic [31:0] exp_araddr, exp_word;
  logic [7:0]  exp_arlen;
  logic [1:0]  exp_arburst;
  logic [2:0]  exp_arsize;
  logic [31:0] mline [BEATS];

  logic [31:0] gdata [BEATS];
  logic [1:0]  gresp [BEATS];
  logic [31:0] seen_araddr;
  logic [7:0]  seen_arlen;
  logic [1:0]  seen_arburst;
  logic [2:0]  seen_arsize;

  task automatic chk(input string nm, input logic [LS*8-1:0] act, input logic [LS*8-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [LS*8-1:0] model_line();
    logic [LS*8-1:0] r;
    for (int i = 0; i < BEATS; i++) r[i*32 +: 32] = mline[i];
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("empty", empty, exp_empty);
      chk("done", done, exp_done);
      chk("rready", axi_rready, exp_rready);
      chk("arvalid", axi_arvalid, exp_arvalid);
      chk("resp_err", resp_err, exp_err);
      chk("word_data", word_data, exp_word);
      chk("line_data", line_data, model_line());
      if (exp_arvalid || exp_empty) begin
        chk("araddr", axi_araddr, exp_araddr);
        chk("arlen", axi_arlen, exp_arlen);
        chk("arburst", axi_arburst, exp_arburst);
        chk("arsize", axi_arsize, exp_arsize);
      end
    end
  end

  task automatic clear_ar();
    exp_arvalid = 1'b0; exp_araddr = '0; exp_arlen = '0; exp_arburst = '0; exp_arsize = '0;
  endtask

  task automatic model_reset();
    clear_ar();
    exp_empty = 1'b1; exp_done = 1'b0; exp_rready = 1'b0;
    exp_err = 1'b0; exp_word = '0;
    for (int i = 0; i < BEATS; i++) mline[i] = '0;
  endtask

  task automatic set_ar_exp(input bit unc, input logic [31:0] a, input logic [2:0] sz);
    exp_arvalid = 1'b1;
    if (unc) begin
      exp_araddr = a; exp_arlen = 8'd0; exp_arburst = 2'b00; exp_arsize = sz;
    end else begin
      exp_araddr  = WRAP ? a - (a % 4) : a - (a % LS);
      exp_arburst = WRAP ? 2'b10 : 2'b01;
      exp_arlen   = 8'(BEATS - 1);
      exp_arsize  = 3'b010;
    end
  endtask

  task automatic junk_inputs();
    en       = 1'($urandom);
    uncached = 1'($urandom);
    addr     = $urandom;
    size     = 3'($urandom);
    axi_rvalid = 1'($urandom);
    axi_rdata  = $urandom;
    axi_rresp  = 2'($urandom);
    axi_rlast  = 1'($urandom);
  endtask

  task automatic idle_cycle();
    junk_inputs();
    en = 1'b0;
    axi_arready = 1'($urandom);
    @(posedge clk); #1;
  endtask

  // Entered at posedge+1 with the DUT idle; returns at posedge+1 of the first idle cycle after done.
  // rv_mode: 0 rvalid always, 1 random, 2 alternating. abort_after >= 0 pulses rst after that many beats.
  task automatic do_req(input bit unc, input logic [31:0] a, input logic [2:0] sz, input int ar_delay,
                        input int rv_mode, input bit given, input int abort_after);
    int n, idx, got, miss;
    bit v, ph;
    logic [31:0] d;
    logic [1:0]  rs;
    junk_inputs();
    en = 1'b1; uncached = unc; addr = a; size = sz;
    axi_arready = (ar_delay == 0);
    set_ar_exp(unc, a, sz);
    exp_empty = 1'b1; exp_done = 1'b0; exp_rready = 1'b0;
    @(negedge clk);
    seen_araddr = axi_araddr; seen_arlen = axi_arlen; seen_arburst = axi_arburst; seen_arsize = axi_arsize;
    @(posedge clk); #1;
    exp_err = 1'b0;
    exp_empty = 1'b0;
    for (int k = 1; k <= ar_delay; k++) begin
      junk_inputs();
      axi_arready = (k == ar_delay);
      @(posedge clk); #1;
    end
    clear_ar();
    exp_rready = 1'b1;
    n   = unc ? 1 : BEATS;
    idx = (WRAP && !unc) ? int'((a % LS) / 4) : 0;
    got = 0; miss = 0; ph = 1'b1;
    while (got < n) begin
      junk_inputs();
      axi_arready = 1'($urandom);
      if (abort_after >= 0 && got == abort_after) begin
        rst = 1'b1; axi_rvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b0;
        model_reset();
        return;
      end
      case (rv_mode)
        0:       v = 1'b1;
        1:       v = (miss >= 8) ? 1'b1 : 1'($urandom);
        default: begin v = ph; ph = ~ph; end
      endcase
      d  = given ? gdata[got] : $urandom;
      rs = given ? gresp[got] : (($urandom % 6 == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1)));
      axi_rvalid = v; axi_rdata = d; axi_rresp = rs;
      @(posedge clk); #1;
      if (v) begin
        mline[idx] = d;
        if (unc) exp_word = d;
        exp_err = exp_err | rs[1];
        idx = (idx + 1) % BEATS;
        got++; miss = 0;
      end else miss++;
    end
    exp_rready = 1'b0; exp_done = 1'b1;
    junk_inputs();
    axi_arready = 1'($urandom);
    @(posedge clk); #1;
    model_reset_outputs_only();
  endtask

  task automatic model_reset_outputs_only();
    clear_ar();
    exp_empty = 1'b1; exp_done = 1'b0; exp_rready = 1'b0;
    en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; uncached = 1'b0; addr = '0; size = '0;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = '0; axi_rlast = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_on = 1'b1;
    idle_cycle();

    // uncached single beat, minimum latency
    gdata[0] = 32'hDEADBEEF; gresp[0] = 2'b00;
    do_req(1'b1, 32'h1FC0_0004, 3'd2, 0, 0, 1'b1, -1);
    chk("t1_arlen", seen_arlen, 8'd0);
    chk("t1_arburst", seen_arburst, 2'b00);
    chk("t1_arsize", seen_arsize, 3'd2);
    chk("t1_word", word_data, 32'hDEADBEEF);
    chk("t1_err", resp_err, 1'b0);
    idle_cycle();

    // cached line with AR stalled three cycles
    gdata[0] = 32'h11; gdata[1] = 32'h22; gdata[2] = 32'h33; gdata[3] = 32'h44;
    for (int i = 0; i < BEATS; i++) gresp[i] = 2'b00;
    do_req(1'b0, 32'h8000_0018, 3'd0, 3, 0, 1'b1, -1);
    chk("t2_arlen", seen_arlen, 8'd3);
    if (WRAP) begin
      chk("t2_araddr", seen_araddr, 32'h8000_0018);
      chk("t2_arburst", seen_arburst, 2'b10);
      chk("t2_line", line_data, 128'h00000022_00000011_00000044_00000033);
    end else begin
      chk("t2_araddr", seen_araddr, 32'h8000_0010);
      chk("t2_arburst", seen_arburst, 2'b01);
      chk("t2_line", line_data, 128'h00000044_00000033_00000022_00000011);
    end
    idle_cycle();

    // gapped rvalid with one SLVERR beat
    gresp[0] = 2'b00; gresp[1] = 2'b10; gresp[2] = 2'b00; gresp[3] = 2'b00;
    do_req(1'b0, 32'h0000_1230, 3'd0, 1, 2, 1'b1, -1);
    chk("t3_err", resp_err, 1'b1);

    // back-to-back: next request in the first idle cycle after done
    do_req(1'b0, $urandom, 3'd0, 0, 1, 1'b0, -1);
    do_req(1'b1, $urandom, 3'd1, 2, 1, 1'b0, -1);
    do_req(1'b0, $urandom, 3'd0, 0, 0, 1'b0, -1);

    // reset after beat 2 of a cached burst
    do_req(1'b0, 32'h4000_0040, 3'd0, 0, 0, 1'b0, 2);
    chk("t5_empty", empty, 1'b1);
    chk("t5_rready", axi_rready, 1'b0);
    chk("t5_line", line_data, '0);
    idle_cycle();

    for (int t = 0; t < 200; t++) begin
      do_req(1'($urandom), $urandom, 3'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
             1, 1'b0, -1);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    idle_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
